drum_step_sequencer: RTL and testbench
======================================

// Module: drum_step_sequencer
// PURPOSE
//  Pattern step sequencer that schedules the drum voices from the divided tempo clock.
//  Samples the divider's clk_tx as a tempo tick and counts ticks into steps.
//  On each step it fires fixed-width trigger pulses to the voice generators enabled in the
//  programmable pattern memory. Sits between the tempo divider and the per-voice sample players.
// PARAMETERS
//  STEPS          16  pattern length in steps (power of 2, >=2)
//  VOICES          4  number of drum voices / trigger outputs
//  TICKS_PER_STEP  6  tempo ticks per sequencer step (>=1)
//  TRIG_LEN        4  trigger pulse width in clk_rx cycles (>=1)
// PORTS
//  clk_rx     in   1                system clock
//  nrst       in   1                asynchronous, active-low reset
//  tick       in   1                divided tempo clock (divider clk_tx); async to use, level signal
//  start      in   1                1-cycle pulse: (re)start playback from step 0
//  stop       in   1                1-cycle pulse: stop playback
//  pat_we     in   1                pattern write enable
//  pat_addr   in   $clog2(STEPS)    pattern step address
//  pat_wdata  in   VOICES           voice-enable bits for that step
//  trig       out  VOICES           per-voice trigger pulses
//  step       out  $clog2(STEPS)    current step index
//  running    out  1                high while in RUN
//  beat       out  1                1-cycle pulse whenever step 0 fires
// BEHAVIOUR
//  - Reset is async and active-low; clock is clk_rx, all logic is on the posedge.
//    Under reset: state=IDLE; trig=0, step=0, running=0, beat=0; tick_cnt=0;
//    trigger counters=0; all pattern bits=0; synchroniser flops=0.
//  - Tick path: 2-FF synchroniser on tick, then rising-edge detect gives tick_p
//    (1 cycle). tick_p asserts 3 clk_rx cycles after the tick rise. Falling edges are ignored.
//  - FSM states IDLE, RUN.
//    IDLE: step=0, tick_cnt=0, tick_p ignored. start -> RUN and fire step 0.
//    RUN: on tick_p, if tick_cnt==TICKS_PER_STEP-1 then tick_cnt<=0, step<=step+1
//      (wraps STEPS-1 -> 0) and the new step fires; otherwise tick_cnt<=tick_cnt+1.
//      start in RUN: resync, step<=0, tick_cnt<=0, fire step 0; a tick_p in the
//      same cycle is discarded. stop in RUN -> IDLE, step<=0, tick_cnt<=0.
//    start and stop in the same cycle: stop wins, in either state.
//  - Fire step s: for each voice v with pattern[s][v]==1, load trig counter v with
//    TRIG_LEN. trig[v] = (counter v != 0); the counter decrements each cycle.
//    Output is registered: trig rises the cycle after the fire decision and stays high
//    exactly TRIG_LEN cycles. A fire while the counter is nonzero reloads it, so the pulse
//    extends with no low gap. beat=1 for 1 cycle, aligned with trig, when s==0.
//  - Stop does not truncate trig pulses already in progress; they complete. running
//    drops the cycle after stop is sampled.
//  - Pattern memory is STEPS x VOICES flops. A write lands at the clock edge.
//    A step fired in the same cycle as a write to its address uses the old contents.
//    Writes are legal in any state.
//  - Widths: tick_cnt is $clog2(TICKS_PER_STEP+1) bits. step wraps naturally because
//    STEPS is a power of 2. No tick_p is lost or double-counted at the wrap.
//  - Reset mid-playback: returns to IDLE immediately and clears the pattern; any pulse in
//    progress is cut.
// TESTING
//  1 Reset: nrst low mid-run with trig active -> all outputs 0 asynchronously; pattern reads back all 0.
//  2 pattern[0]=4'b1001, pattern[1]=4'b0010, start -> trig=1001 for 4 cycles + beat;
//    6 tick rises later -> step=1, trig=0010 for 4 cycles.
//  3 Wrap: pattern[15]=4'b0100, pattern[0]=4'b0001; run 96 tick rises -> step 15 fires 0100,
//    then step 0 fires 0001 with beat; step goes 15->0.
//  4 Back-to-back: TRIG_LEN=4, TICKS_PER_STEP=1, tick period 3 cycles, voice0 set every step ->
//    trig[0] stays high continuously with no gap.
//  5 start+stop same cycle in RUN -> IDLE, step=0, running=0, no new trig;
//    start alone in RUN at step 7 -> step=0 and step 0 fires.
//  6 Write pattern[3]=4'b1111 in the cycle step 3 fires (old value 0000) -> trig stays 0 for this pass;
//    the next pass fires 1111.

Source files
------------

// File: rtl/drum_step_sequencer.sv
// Drum pattern step sequencer.
// Turns the divided tempo clock into sequencer steps and fires fixed-width
// trigger pulses to every voice enabled in the programmable pattern memory.
//
// Handshake note: this block has no valid/ready interfaces. start, stop and
// pat_we are single-cycle strobes sampled on the rising edge of clk_rx; tick is
// an asynchronous level that is synchronised here.
module drum_step_sequencer #(
    parameter int STEPS          = 16,
    parameter int VOICES         = 4,
    parameter int TICKS_PER_STEP = 6,
    parameter int TRIG_LEN       = 4
) (
    input  logic                     clk_rx,
    input  logic                     nrst,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pat_we,
    input  logic [$clog2(STEPS)-1:0] pat_addr,
    input  logic [VOICES-1:0]        pat_wdata,
    output logic [VOICES-1:0]        trig,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     running,
    output logic                     beat
);

    localparam int SW  = $clog2(STEPS);
    localparam int TCW = $clog2(TICKS_PER_STEP + 1);
    localparam int LW  = $clog2(TRIG_LEN + 1);

    localparam logic [TCW-1:0] TC_LAST = TCW'(TICKS_PER_STEP - 1);
    localparam logic [LW-1:0]  LEN     = LW'(TRIG_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [SW-1:0]     step_n;
    logic [TCW-1:0]    tick_cnt, tick_cnt_n;
    logic              fire;
    logic [SW-1:0]     fire_step;
    logic [VOICES-1:0] fire_bits;

    logic              tick_s1, tick_s2, tick_s2_d, tick_p;

    logic [VOICES-1:0] pattern [STEPS];
    logic [LW-1:0]     trig_cnt [VOICES];

    // Two-flop synchroniser plus registered rising-edge detect; tick_p is high
    // for one cycle, three clk_rx edges after tick rises.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            tick_s2_d <= 1'b0;
            tick_p    <= 1'b0;
        end else begin
            tick_s1   <= tick;
            tick_s2   <= tick_s1;
            tick_s2_d <= tick_s2;
            tick_p    <= tick_s2 & ~tick_s2_d;
        end
    end

    // Pattern memory; a write lands at the edge, so a same-cycle fire reads old data.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < STEPS; i++) begin
                pattern[i] <= '0;
            end
        end else if (pat_we) begin
            pattern[pat_addr] <= pat_wdata;
        end
    end

    // FSM state, step index and tick counter registers.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            step     <= '0;
            tick_cnt <= '0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            tick_cnt <= tick_cnt_n;
        end
    end

    // Next-state logic and fire decision; stop outranks start in both states.
    always_comb begin
        state_n    = state;
        step_n     = step;
        tick_cnt_n = tick_cnt;
        fire       = 1'b0;
        fire_step  = step;
        case (state)
            IDLE: begin
                step_n     = '0;
                tick_cnt_n = '0;
                if (!stop && start) begin
                    state_n   = RUN;
                    fire      = 1'b1;
                    fire_step = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n    = IDLE;
                    step_n     = '0;
                    tick_cnt_n = '0;
                end else if (start) begin
                    // Restart discards any tick_p arriving in the same cycle.
                    step_n     = '0;
                    tick_cnt_n = '0;
                    fire       = 1'b1;
                    fire_step  = '0;
                end else if (tick_p) begin
                    if (tick_cnt == TC_LAST) begin
                        tick_cnt_n = '0;
                        step_n     = step + 1'b1;
                        fire       = 1'b1;
                        fire_step  = step + 1'b1;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Voice enables of the step being fired this cycle.
    always_comb begin
        fire_bits = pattern[fire_step];
    end

    // Per-voice pulse counters; a fire reloads so back-to-back pulses merge.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            for (int v = 0; v < VOICES; v++) begin
                trig_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (fire && fire_bits[v]) begin
                    trig_cnt[v] <= LEN;
                end else if (trig_cnt[v] != '0) begin
                    trig_cnt[v] <= trig_cnt[v] - 1'b1;
                end
            end
        end
    end

    // Beat marks step 0 firing, aligned with the trig rise.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            beat <= 1'b0;
        end else begin
            beat <= fire && (fire_step == '0);
        end
    end

    // Trigger outputs follow the registered counters.
    always_comb begin
        trig = '0;
        for (int v = 0; v < VOICES; v++) begin
            trig[v] = (trig_cnt[v] != '0);
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed testbench for drum_step_sequencer.
module tb_drum_step_sequencer;

    logic       clk_rx = 1'b0;
    logic       nrst   = 1'b0;

    // Instance a: default parameters.
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, pat_we = 1'b0;
    logic [3:0] pat_addr = '0, pat_wdata = '0;
    logic [3:0] trig, step;
    logic       running, beat;

    // Instance b: one tick per step for the back-to-back pulse case.
    logic       tick_b = 1'b0, start_b = 1'b0, stop_b = 1'b0, pat_we_b = 1'b0;
    logic [3:0] pat_addr_b = '0, pat_wdata_b = '0;
    logic [3:0] trig_b, step_b;
    logic       running_b, beat_b;

    int n_checks = 0;
    int n_errors = 0;

    drum_step_sequencer u_dut (
        .clk_rx    (clk_rx),
        .nrst      (nrst),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .pat_we    (pat_we),
        .pat_addr  (pat_addr),
        .pat_wdata (pat_wdata),
        .trig      (trig),
        .step      (step),
        .running   (running),
        .beat      (beat)
    );

    drum_step_sequencer #(.TICKS_PER_STEP(1)) u_dut_b (
        .clk_rx    (clk_rx),
        .nrst      (nrst),
        .tick      (tick_b),
        .start     (start_b),
        .stop      (stop_b),
        .pat_we    (pat_we_b),
        .pat_addr  (pat_addr_b),
        .pat_wdata (pat_wdata_b),
        .trig      (trig_b),
        .step      (step_b),
        .running   (running_b),
        .beat      (beat_b)
    );

    // Clock
    always #5 clk_rx = ~clk_rx;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk_rx);
    endtask

    task automatic write_pat(input logic [3:0] addr, input logic [3:0] data);
        pat_we = 1'b1; pat_addr = addr; pat_wdata = data;
        cycle();
        pat_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    // One tick rise; tick_p is consumed at the 4th edge, which this task ends after.
    // Optionally a pattern write is presented for that same edge.
    task automatic tick_rise(input bit do_wr, input logic [3:0] addr, input logic [3:0] data);
        tick = 1'b1;
        cycle();
        cycle();
        tick = 1'b0;
        cycle();
        if (do_wr) begin
            pat_we = 1'b1; pat_addr = addr; pat_wdata = data;
        end
        cycle();
        pat_we = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_rise(1'b0, 4'd0, 4'd0);
        end
    endtask

    initial begin
        int gaps;

        // Reset
        cycle();
        cycle();
        check("rst_trig", trig, 4'b0000);
        check("rst_step", step, 4'd0);
        check("rst_running", running, 1'b0);
        check("rst_beat", beat, 1'b0);
        nrst = 1'b1;
        cycle();

        // Basic fire and step advance
        write_pat(4'd0, 4'b1001);
        write_pat(4'd1, 4'b0010);
        pulse_start();
        check("s0_trig", trig, 4'b1001);
        check("s0_beat", beat, 1'b1);
        check("s0_running", running, 1'b1);
        check("s0_step", step, 4'd0);
        cycle();
        check("s0_trig_c2", trig, 4'b1001);
        check("s0_beat_c2", beat, 1'b0);
        cycle();
        cycle();
        check("s0_trig_c4", trig, 4'b1001);
        cycle();
        check("s0_trig_end", trig, 4'b0000);
        ticks(5);
        check("t5_step", step, 4'd0);
        ticks(1);
        check("s1_step", step, 4'd1);
        check("s1_trig", trig, 4'b0010);
        check("s1_beat", beat, 1'b0);
        cycle(); cycle(); cycle();
        check("s1_trig_c4", trig, 4'b0010);
        cycle();
        check("s1_trig_end", trig, 4'b0000);

        // Wrap 15 -> 0
        pulse_stop();
        check("stop_running", running, 1'b0);
        write_pat(4'd15, 4'b0100);
        write_pat(4'd0, 4'b0001);
        pulse_start();
        check("wrap_s0_trig", trig, 4'b0001);
        ticks(90);
        check("wrap_s15_step", step, 4'd15);
        check("wrap_s15_trig", trig, 4'b0100);
        check("wrap_s15_beat", beat, 1'b0);
        ticks(6);
        check("wrap_s0_step", step, 4'd0);
        check("wrap_s0_trig2", trig, 4'b0001);
        check("wrap_s0_beat", beat, 1'b1);

        // start+stop together in RUN: stop wins
        cycle(); cycle(); cycle(); cycle();
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check("ss_running", running, 1'b0);
        check("ss_step", step, 4'd0);
        check("ss_trig", trig, 4'b0000);
        check("ss_beat", beat, 1'b0);
        cycle(); cycle();
        check("ss_trig_later", trig, 4'b0000);

        // Restart in RUN at step 7
        pulse_start();
        ticks(42);
        check("rs_step7", step, 4'd7);
        cycle(); cycle(); cycle(); cycle();
        pulse_start();
        check("rs_step", step, 4'd0);
        check("rs_trig", trig, 4'b0001);
        check("rs_beat", beat, 1'b1);
        check("rs_running", running, 1'b1);

        // Stop does not truncate the pulse in progress
        pulse_stop();
        check("sp_running", running, 1'b0);
        check("sp_trig", trig, 4'b0001);
        cycle(); cycle();
        check("sp_trig_c4", trig, 4'b0001);
        cycle();
        check("sp_trig_end", trig, 4'b0000);

        // Write collides with the fire of the same step
        pulse_start();
        ticks(17);
        check("wc_step2", step, 4'd2);
        tick_rise(1'b1, 4'd3, 4'b1111);
        check("wc_step3", step, 4'd3);
        check("wc_trig_old", trig, 4'b0000);
        cycle(); cycle(); cycle(); cycle();
        ticks(96);
        check("wc_step3_again", step, 4'd3);
        check("wc_trig_new", trig, 4'b1111);

        // Async reset mid-pulse
        cycle();
        #2;
        nrst = 1'b0;
        #1;
        check("ar_trig", trig, 4'b0000);
        check("ar_running", running, 1'b0);
        check("ar_step", step, 4'd0);
        check("ar_beat", beat, 1'b0);
        cycle();
        nrst = 1'b1;
        cycle();
        pulse_start();
        check("ar_s0_trig", trig, 4'b0000);
        check("ar_s0_beat", beat, 1'b1);
        ticks(6);
        check("ar_s1_step", step, 4'd1);
        check("ar_s1_trig", trig, 4'b0000);
        ticks(12);
        check("ar_s3_step", step, 4'd3);
        check("ar_s3_trig", trig, 4'b0000);

        // Back-to-back pulses on instance b: one tick per step, tick period 3 cycles
        for (int s = 0; s < 16; s++) begin
            pat_we_b = 1'b1; pat_addr_b = 4'(s); pat_wdata_b = 4'b0001;
            cycle();
        end
        pat_we_b = 1'b0;
        gaps = 0;
        for (int k = 0; k < 30; k++) begin
            tick_b = 1'b1;
            if (k == 0) start_b = 1'b1;
            cycle();
            start_b = 1'b0;
            tick_b = 1'b0;
            if (trig_b[0] !== 1'b1) gaps++;
            cycle();
            if (trig_b[0] !== 1'b1) gaps++;
            cycle();
            if (trig_b[0] !== 1'b1) gaps++;
        end
        check("b2b_gaps", gaps, 0);
        cycle(); cycle();
        check("b2b_step", step_b, 4'd14);
        check("b2b_running", running_b, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
